// File: rtl/cc_muxx_pipe.sv
// Pipelined dual-port register-read selector: two addressed channels, registered, valid/ready.
// Ports: clk/rst, flattened channel bus, A/B addresses, req/rsp handshake, A/B data, addrErr. Option: CC_MUXX_PIPE_ZERO_REG_EN.
module cc_muxx_pipe #(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int DATAWIDTH_MIR_DIRECTION = 6,
  parameter int NUM_CHANNELS            = 16
) (
  input  logic                                  CC_MUXX_PIPE_CLOCK_50,
  input  logic                                  CC_MUXX_PIPE_RESET_InHigh,
  input  logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0] CC_MUXX_PIPE_data_InBus,
  input  logic [DATAWIDTH_MIR_DIRECTION-1:0]    CC_MUXX_PIPE_AddressA_InBus,
  input  logic [DATAWIDTH_MIR_DIRECTION-1:0]    CC_MUXX_PIPE_AddressB_InBus,
  input  logic                                  CC_MUXX_PIPE_reqValid_In,
  output logic                                  CC_MUXX_PIPE_reqReady_Out,
  output logic [DATAWIDTH_BUS-1:0]              CC_MUXX_PIPE_dataA_OutBus,
  output logic [DATAWIDTH_BUS-1:0]              CC_MUXX_PIPE_dataB_OutBus,
  output logic                                  CC_MUXX_PIPE_rspValid_Out,
  input  logic                                  CC_MUXX_PIPE_rspReady_In,
  output logic [1:0]                            CC_MUXX_PIPE_addrErr_Out
);

  localparam int W  = DATAWIDTH_BUS;
  localparam int AW = DATAWIDTH_MIR_DIRECTION;
  localparam logic [AW:0] NCH = NUM_CHANNELS[AW:0];

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic              clk;
  logic              rst;
  logic [0:0]        state;
  logic              accept;
  logic              rsp_valid;
  logic [W-1:0]      ch [NUM_CHANNELS];
  logic [1:0][AW-1:0] addr;
  logic [1:0][W-1:0] res;
  logic [1:0]        err;

  assign clk = CC_MUXX_PIPE_CLOCK_50;
  assign rst = CC_MUXX_PIPE_RESET_InHigh;

  assign addr[0] = CC_MUXX_PIPE_AddressA_InBus;
  assign addr[1] = CC_MUXX_PIPE_AddressB_InBus;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    assign ch[k] = CC_MUXX_PIPE_data_InBus[k*W +: W];
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [W-1:0] pick;

    // No match (out of range) leaves channel 0 selected.
    always_comb begin
      pick = ch[0];
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (addr[p] == k[AW-1:0]) pick = ch[k];
      end
    end

    // Constant-false when every address value is a real channel.
    assign err[p] = !({1'b0, addr[p]} < NCH);

`ifdef CC_MUXX_PIPE_ZERO_REG_EN
    assign res[p] = (err[p] || addr[p] == '0) ? '0 : pick;
`else
    assign res[p] = pick;
`endif
  end

  assign rsp_valid = (state == FULL);
  assign CC_MUXX_PIPE_rspValid_Out = rsp_valid;

  // Reset term keeps ready high even while a stalled result is being flushed.
  assign CC_MUXX_PIPE_reqReady_Out = rst || !rsp_valid || CC_MUXX_PIPE_rspReady_In;

  assign accept = CC_MUXX_PIPE_reqValid_In && CC_MUXX_PIPE_reqReady_Out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= EMPTY;
      CC_MUXX_PIPE_dataA_OutBus <= '0;
      CC_MUXX_PIPE_dataB_OutBus <= '0;
      CC_MUXX_PIPE_addrErr_Out  <= 2'b00;
    end else if (accept) begin
      state                     <= FULL;
      CC_MUXX_PIPE_dataA_OutBus <= res[0];
      CC_MUXX_PIPE_dataB_OutBus <= res[1];
      CC_MUXX_PIPE_addrErr_Out  <= err;
    end else if (rsp_valid && CC_MUXX_PIPE_rspReady_In) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_cc_muxx_pipe.sv
// Directed bench for cc_muxx_pipe with an expected-result queue.
// Default parameters; zero-register expectations follow CC_MUXX_PIPE_ZERO_REG_EN.
module tb_cc_muxx_pipe;

  localparam int W  = 32;
  localparam int AW = 6;
  localparam int N  = 16;

`ifdef CC_MUXX_PIPE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [W-1:0]  chv [N];
  logic [N*W-1:0] data_bus;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  data_a;
  logic [W-1:0]  data_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    addr_err;

  int checks = 0;
  int errors = 0;
  logic [65:0] sb [$];

  always_comb begin
    data_bus = '0;
    for (int k = 0; k < N; k++) data_bus[k*W +: W] = chv[k];
  end

  cc_muxx_pipe #(
    .DATAWIDTH_BUS(W),
    .DATAWIDTH_MIR_DIRECTION(AW),
    .NUM_CHANNELS(N)
  ) dut (
    .CC_MUXX_PIPE_CLOCK_50(clk),
    .CC_MUXX_PIPE_RESET_InHigh(rst),
    .CC_MUXX_PIPE_data_InBus(data_bus),
    .CC_MUXX_PIPE_AddressA_InBus(addr_a),
    .CC_MUXX_PIPE_AddressB_InBus(addr_b),
    .CC_MUXX_PIPE_reqValid_In(req_valid),
    .CC_MUXX_PIPE_reqReady_Out(req_ready),
    .CC_MUXX_PIPE_dataA_OutBus(data_a),
    .CC_MUXX_PIPE_dataB_OutBus(data_b),
    .CC_MUXX_PIPE_rspValid_Out(rsp_valid),
    .CC_MUXX_PIPE_rspReady_In(rsp_ready),
    .CC_MUXX_PIPE_addrErr_Out(addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [65:0] obs,
                       input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [AW-1:0] a);
    if (a >= AW'(N)) return ZERO ? '0 : chv[0];
    if (ZERO && a == '0) return '0;
    return chv[a];
  endfunction

  // Handshakes are evaluated on values settled before the edge.
  task automatic tick();
    logic [65:0] e;
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", {data_a, data_b, addr_err}, 'x);
        end else begin
          e = sb.pop_front();
          check("sb_result", {data_a, data_b, addr_err}, e);
        end
      end
      if (req_valid && req_ready) begin
        sb.push_back({model(addr_a), model(addr_b),
                      addr_b >= AW'(N), addr_a >= AW'(N)});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    addr_a = '0;
    addr_b = '0;
    for (int k = 0; k < N; k++) chv[k] = 32'hA000_0000 + k;
    tick();
    check("rst_valid", 66'(rsp_valid), 66'(0));
    check("rst_data", {data_a, data_b, addr_err}, 66'(0));
    check("rst_ready", 66'(req_ready), 66'(1));
    rst = 1'b0;
    tick();
    check("post_rst_ready", 66'(req_ready), 66'(1));

    // Basic read
    req_valid = 1'b1;
    addr_a = 6'd5;
    addr_b = 6'd12;
    tick();
    req_valid = 1'b0;
    check("basic_a", 66'(data_a), 66'(32'hA000_0005));
    check("basic_b", 66'(data_b), 66'(32'hA000_000C));
    check("basic_vld_err", 66'({rsp_valid, addr_err}), 66'(3'b100));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("drain_valid", 66'(rsp_valid), 66'(0));
    check("drain_keep", 66'(data_a), 66'(32'hA000_0005));

    // Out of range
    chv[0] = 32'h1234_5678;
    addr_a = 6'd20;
    addr_b = 6'd63;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("oor_a", 66'(data_a), 66'(ZERO ? 32'h0 : 32'h1234_5678));
    check("oor_b", 66'(data_b), 66'(ZERO ? 32'h0 : 32'h1234_5678));
    check("oor_err", 66'(addr_err), 66'(2'b11));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chv[0] = 32'hA000_0000;

    // Backpressure
    addr_a = 6'd3;
    addr_b = 6'd3;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chv[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      check("hold_a", 66'(data_a), 66'(32'hA000_0003));
      check("hold_ready", 66'({req_ready, rsp_valid}), 66'(2'b01));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hold_once", 66'(rsp_valid), 66'(0));
    chv[3] = 32'hA000_0003;

    // Streaming
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr_a = AW'(i);
      addr_b = AW'(15 - i);
      tick();
      check("stream_valid", 66'(rsp_valid), 66'(1));
      check("stream_a", 66'(data_a), 66'(32'hA000_0000 + i));
    end
    req_valid = 1'b0;
    tick();
    check("stream_end", 66'({rsp_valid, 32'(sb.size())}), 66'(0));
    rsp_ready = 1'b0;

    // Zero register
    chv[0] = 32'hFFFF_FFFF;
    addr_a = 6'd0;
    addr_b = 6'd0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("zero_a", 66'(data_a), 66'(ZERO ? 32'h0 : 32'hFFFF_FFFF));
    check("zero_b", 66'(data_b), 66'(ZERO ? 32'h0 : 32'hFFFF_FFFF));
    check("zero_err", 66'(addr_err), 66'(2'b00));

    // Reset while the zero-register result is held
    tick();
    check("pre_rst_hold", 66'({rsp_valid, req_ready}), 66'(2'b10));
    rst = 1'b1;
    #1;
    check("rst_ready_in", 66'(req_ready), 66'(1));
    tick();
    rst = 1'b0;
    check("rst_hold_state", {data_a, data_b, addr_err}, 66'(0));
    check("rst_hold_vr", 66'({rsp_valid, req_ready}), 66'(2'b01));
    tick();
    check("rst_no_rsp", 66'(rsp_valid), 66'(0));
    check("sb_empty", 66'(sb.size()), 66'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
